copro_result_queue: RTL
=======================

Name: copro_result_queue

Overview:
- Result-side buffer between the coprocessor ALU and the CV-X-IF result interface toward the core.
- Captures the ALU's one-cycle registered result pulses into a Depth-entry FIFO and presents them to the core with a valid/ready handshake.
- Uses credit-based issue throttling so that no ALU result is ever lost to core back-pressure.

Parameters:
- XLEN, 32, result data width
- HartIdWidth, 1, width of hart identifier
- IdWidth, 4, width of instruction identifier
- Depth, 4, FIFO entries; power of two, >= 2

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_fire_i  in  1  core issue handshake completed this cycle; ALU result arrives exactly next cycle
- issue_ready_o  out  1  queue can absorb one more issued instruction
- alu_valid_i  in  1  ALU result valid (single-cycle pulse per instruction)
- alu_hartid_i  in  HartIdWidth  ALU result hart id
- alu_id_i  in  IdWidth  ALU result instruction id
- alu_rd_i  in  5  ALU destination register
- alu_we_i  in  1  ALU register write enable
- alu_result_i  in  XLEN  ALU result data
- result_valid_o  out  1  head entry valid toward core
- result_ready_i  in  1  core accepts head entry
- result_hartid_o  out  HartIdWidth  head hart id
- result_id_o  out  IdWidth  head instruction id
- result_rd_o  out  5  head rd
- result_we_o  out  1  head write enable
- result_data_o  out  XLEN  head data
- flush_i  in  1  synchronous flush of all buffered and in-flight results
- count_o  out  $clog2(Depth)+1  entries currently stored
- overflow_o  out  1  sticky error: push attempted while full

Behaviour:
- Reset values: all pointers, count and inflight_q are 0. result_valid_o=0, result_* payload=0, count_o=0, overflow_o=0, issue_ready_o=1.
- Storage:
  - Circular FIFO with write pointer, read pointer and count; pointers wrap modulo Depth.
  - Each entry holds {hartid, id, rd, we, data}.
- Every alu_valid_i pulse is enqueued, including we=0 (NOP) results.
- Push: alu_valid_i=1 and no flush.
- Pop: result_valid_o=1 and result_ready_i=1.
- Outputs: result_valid_o = (count != 0). result_* driven directly from the head entry; payload is 0 when empty.
- No bypass: a pushed entry is visible on result_valid_o the cycle after alu_valid_i. End-to-end latency from issue_fire_i to result_valid_o is 2 cycles.
- Handshake: while result_valid_o=1 and result_ready_i=0, the head payload stays stable.
- In-flight tracking: inflight_q <= issue_fire_i each cycle (ALU latency is fixed at 1).
- Credits: issue_ready_o = (count + inflight_q) < Depth, evaluated on current registered state. issue_ready_o does not depend combinationally on result_ready_i.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - Legal even when count==Depth: the slot freed by the pop is reused.
- Overflow:
  - Condition: push with count==Depth and no pop.
  - The incoming entry is dropped and state is unchanged.
  - overflow_o sets and stays 1 until reset; flush does not clear it.
  - Cannot occur when the core respects issue_ready_o.
- alu_valid_i without a prior issue_fire_i is still enqueued. inflight_q is not decremented below 0.
- Flush (flush_i=1):
  - Next cycle: pointers, count and inflight_q are 0; result_valid_o=0.
  - A push or pop in the same cycle is discarded.
  - The alu_valid_i arriving in the cycle after a flush is dropped when inflight_q was cleared, but only if it corresponds to an issue_fire_i from the flush cycle or earlier.
  - Implementation: register flush_q; suppress push when flush_q && inflight-before-flush.
- Reset mid-operation: all state clears asynchronously; outputs return to reset values immediately.

Test Plan:
- Single result: issue_fire_i at cycle 0, alu_valid_i at cycle 1 with id=3, rd=5, data=0x0000_00AA, result_ready_i=1 → result_valid_o=1 at cycle 2 with id=3, rd=5, data=0xAA; count_o returns to 0 at cycle 3.
- Back-pressure fill: result_ready_i=0, issue 4 back-to-back with ids 0..3 → issue_ready_o=0 once count+inflight=4 (after third accepted result plus one in flight); count_o=4. Then result_ready_i=1 → ids pop in order 0,1,2,3, one per cycle.
- Full push+pop: count=4, alu_valid_i and result_ready_i both 1 in the same cycle → count stays 4, no overflow, new entry lands at the wrapped tail, FIFO order preserved.
- Overflow: count=4, result_ready_i=0, alu_valid_i=1 with id=9 → entry dropped, overflow_o=1 and stays 1 after a subsequent flush.
- Flush: count=3, issue_fire_i and flush_i both 1 → next cycle count_o=0 and result_valid_o=0; the following alu_valid_i is dropped; issue_ready_o=1.
- Async reset mid-stream: assert rst_ni=0 with count=2 → result_valid_o=0, count_o=0, overflow_o=0 without a clock edge.

Source files
------------

// File: rtl/copro_result_queue.sv
// Result buffer between the coprocessor ALU and the CV-X-IF result interface.
// Credit-throttled FIFO: issue is only allowed while a free slot is guaranteed.
module copro_result_queue #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HartIdWidth = 1,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned Depth       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_fire_i,
  output logic                     issue_ready_o,
  input  logic                     alu_valid_i,
  input  logic [HartIdWidth-1:0]   alu_hartid_i,
  input  logic [IdWidth-1:0]       alu_id_i,
  input  logic [4:0]               alu_rd_i,
  input  logic                     alu_we_i,
  input  logic [XLEN-1:0]          alu_result_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [HartIdWidth-1:0]   result_hartid_o,
  output logic [IdWidth-1:0]       result_id_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o,
  output logic [XLEN-1:0]          result_data_o,
  input  logic                     flush_i,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = HartIdWidth + IdWidth + 5 + 1 + XLEN;

  typedef logic [EntW-1:0] entry_t;

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              inflight_q;
  logic              drop_q;
  logic              overflow_q;

  logic              full;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              overflow_evt;
  logic [CntW:0]     credit_sum;
  entry_t            head;

  assign full           = (count_q == CntW'(Depth));
  assign result_valid_o = (count_q != '0);
  assign pop            = result_valid_o && result_ready_i && !flush_i;
  // drop_q marks the result of an instruction issued in a flush cycle.
  assign push_req       = alu_valid_i && !flush_i && !drop_q;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push           = push_req && (!full || pop);
  assign overflow_evt   = push_req && full && !pop;

  assign credit_sum     = {1'b0, count_q} + (CntW+1)'(inflight_q);
  assign issue_ready_o  = (credit_sum < (CntW+1)'(Depth));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= issue_fire_i && !flush_i;
      drop_q     <= issue_fire_i && flush_i;
      if (overflow_evt) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {alu_hartid_i, alu_id_i, alu_rd_i, alu_we_i, alu_result_i};
    end
  end

  assign head = result_valid_o ? mem_q[rd_ptr_q] : '0;
  assign {result_hartid_o, result_id_o, result_rd_o, result_we_o, result_data_o} = head;

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
